// File: rtl/ai_dma_pkg.sv
// Shared definitions for the AI DMA chain: FSM state encoding and bus constants.
package ai_dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } dma_state_e;

  localparam logic [3:0] DMA_BE_ALL     = 4'hF;
  localparam int         DMA_WORD_BYTES = 4;

endpackage

// File: rtl/dma_stream_writer_if.sv
// Stream sink and Avalon-MM write-master signals of the DMA stream writer.
// The master modport is the DMA side; the slave modport is the attached
// upstream stream stage plus memory slave.
interface dma_stream_writer_if #(
  parameter int ADDR_W = 32
);
  logic              avs_m2_valid;
  logic [31:0]       avs_m2_data;
  logic              avs_m2_startofpacket;
  logic              avs_m2_endofpacket;
  logic              avs_m2_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;

  modport master (
    input  avs_m2_valid, avs_m2_data, avs_m2_startofpacket, avs_m2_endofpacket,
    input  avm_waitrequest,
    output avs_m2_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output avs_m2_valid, avs_m2_data, avs_m2_startofpacket, avs_m2_endofpacket,
    output avm_waitrequest,
    input  avs_m2_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/dma_stream_writer.sv
// Stream-to-memory sink: takes packed-byte stream words and writes them one
// per beat to consecutive word addresses, flagging packet-length mismatches.
module dma_stream_writer
  import ai_dma_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       wr_count,
  dma_stream_writer_if.master bus
);

  logic              b_start;
  logic [ADDR_W-1:2] b_base;
  logic [13:0]       b_words;

  dma_state_e        f_state, n_state;
  logic [ADDR_W-1:0] f_addr, n_addr;
  logic [13:0]       f_remaining, n_remaining;
  logic [31:0]       f_data, n_data;
  logic              f_eop, n_eop;
  logic              f_err, n_err;
  logic [15:0]       f_wr_count, n_wr_count;

  // Byte-offset bits and start-of-packet carry no information for this sink.
  logic unused_bits;
  assign unused_bits = ^{base_addr[1:0], length[1:0], bus.avs_m2_startofpacket};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Register the command inputs every cycle; the FSM only sees these copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_start <= 1'b0;
      b_base  <= '0;
      b_words <= '0;
    end else begin
      b_start <= start;
      b_base  <= base_addr[ADDR_W-1:2];
      b_words <= length[15:2];
    end
  end

  // Next-state and datapath update for the transfer FSM.
  always_comb begin
    n_state     = f_state;
    n_addr      = f_addr;
    n_remaining = f_remaining;
    n_data      = f_data;
    n_eop       = f_eop;
    n_err       = f_err;
    n_wr_count  = f_wr_count;
    unique case (f_state)
      IDLE: begin
        if (b_start) begin
          n_err      = 1'b0;
          n_wr_count = '0;
          if (b_words != 14'd0) begin
            n_addr      = {b_base, 2'b00};
            n_remaining = b_words;
            n_state     = RECV;
          end else begin
            n_state = DONE;
          end
        end
      end
      RECV: begin
        if (bus.avs_m2_valid) begin
          n_data  = bus.avs_m2_data;
          n_eop   = bus.avs_m2_endofpacket;
          n_state = WRITE;
        end
      end
      WRITE: begin
        if (!bus.avm_waitrequest) begin
          n_addr      = f_addr + ADDR_W'(DMA_WORD_BYTES);
          n_remaining = f_remaining - 14'd1;
          n_wr_count  = sat_inc16(f_wr_count);
          if (f_eop) begin
            // eop before the last expected word is a short packet
            if (f_remaining != 14'd1) n_err = 1'b1;
            n_state = DONE;
          end else if (f_remaining == 14'd1) begin
            // buffer full but packet continues: swallow the rest
            n_err   = 1'b1;
            n_state = DRAIN;
          end else begin
            n_state = RECV;
          end
        end
      end
      DRAIN: begin
        if (bus.avs_m2_valid && bus.avs_m2_endofpacket) n_state = DONE;
      end
      DONE:    n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end

  // FSM and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_state     <= IDLE;
      f_addr      <= '0;
      f_remaining <= '0;
      f_data      <= '0;
      f_eop       <= 1'b0;
      f_err       <= 1'b0;
      f_wr_count  <= '0;
    end else begin
      f_state     <= n_state;
      f_addr      <= n_addr;
      f_remaining <= n_remaining;
      f_data      <= n_data;
      f_eop       <= n_eop;
      f_err       <= n_err;
      f_wr_count  <= n_wr_count;
    end
  end

  assign busy               = (f_state != IDLE);
  assign done               = (f_state == DONE);
  assign err                = f_err;
  assign wr_count           = f_wr_count;
  assign bus.avs_m2_ready   = (f_state == RECV) || (f_state == DRAIN);
  assign bus.avm_write      = (f_state == WRITE);
  assign bus.avm_address    = f_addr;
  assign bus.avm_writedata  = f_data;
  assign bus.avm_byteenable = DMA_BE_ALL;

endmodule
